alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Execute-issue stage directly upstream of myALU. Takes a decoded RV32I instruction,
//  maps opcode/funct3/funct7 onto myALU's 4-bit sel encoding, and selects in1/in2.
//  Registers the result behind a valid/ready handshake with a 2-entry skid buffer.
//  Outputs feed myALU combinationally, so alu_sel/alu_in1/alu_in2 are stable for one cycle.
// PARAMETERS
//  XLEN     32  operand width; must equal myALU width
//  PC_STEP  4   link-address increment used for JAL/JALR
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     synchronous active-low reset
//  flush      in   1     synchronous pipeline kill (branch redirect)
//  in_valid   in   1     decoded instruction present
//  in_ready   out  1     stage can accept this cycle
//  opcode     in   7     instr[6:0]
//  funct3     in   3     instr[14:12]
//  funct7b5   in   1     instr[30]
//  rs1_idx    in   5     source register index 1 (used by forwarding only)
//  rs2_idx    in   5     source register index 2 (used by forwarding only)
//  rs1_val    in   XLEN  register-file read data 1
//  rs2_val    in   XLEN  register-file read data 2
//  imm        in   XLEN  sign-extended immediate
//  pc         in   XLEN  instruction address
//  out_valid  out  1     issued operation valid
//  out_ready  in   1     downstream (ALU/EX-MEM) accepts
//  alu_sel    out  4     to myALU sel
//  alu_in1    out  XLEN  to myALU in1
//  alu_in2    out  XLEN  to myALU in2
//  illegal    out  1     issued entry carries an unsupported op; alu_sel=4'b1111
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): out_valid=0, skid empty, alu_sel=0, alu_in1=0, alu_in2=0,
//    illegal=0, in_ready=1 on the following cycle.
//  - Latency: 1 cycle from input accept (in_valid&in_ready) to out_valid.
//  - Handshake: transfer on valid&ready. out_valid stays high and the payload stays frozen
//    until out_ready=1. in_ready = !skid_full; it is a registered signal, not derived from out_ready.
//  - Storage: output reg + skid reg. If the input is accepted while the output is stalled, it goes to skid.
//    Skid drains into the output reg on the first out_ready cycle, and in_ready returns high the cycle after.
//    Output order is strictly FIFO. A simultaneous accept and drain with skid empty is a pass-through.
//  - Flush: next edge clears out_valid and skid, and any in_valid that cycle is dropped.
//    Flush wins over accept and over reset-free drain. rst_n=0 overrides flush.
//  - Decode table (sel | in1 | in2):
//    OP     ADD 0010/SUB 0110 (funct7b5) | rs1 | rs2
//    OP     AND 0000, OR 0001, XOR 1100, SLL 1001, SRL 1011 | rs1 | rs2
//    OP     SLT 0111, SLTU 1000 | rs1 | rs2
//    OP-IMM same as OP using imm as in2. funct7b5 is ignored except for shifts.
//    BRANCH BEQ/BNE/BLT/BGE 0111, BLTU/BGEU 1000 | rs1 | rs2
//    LOAD/STORE 0010 | rs1 | imm
//    LUI    0010 | 0 | imm
//    AUIPC  0010 | pc | imm
//    JAL/JALR 0010 | pc | PC_STEP
//  - SRA/SRAI (funct3=101, funct7b5=1), unknown opcodes and unknown funct3 are illegal:
//    illegal=1, alu_sel=4'b1111 (myALU outputs 0), alu_in1/alu_in2 = rs1/rs2 passthrough.
//    Illegal entries still handshake normally.
//  - Widths: every datapath is XLEN bits. pc+PC_STEP is not computed here.
// CONFIGURATION
//  ALU_ISSUE_FWD_EN defined: adds wb_we(1), wb_rd(5) and wb_data(XLEN) input ports.
//    When wb_we && wb_rd!=0 && wb_rd==rsN_idx, wb_data replaces rsN_val before operand select.
//    The substitution applies in the accept cycle only.
//  ALU_ISSUE_FWD_EN undefined: the ports are absent, rsN_val is used as-is, and rs*_idx are unused.
// TESTING
//  1. ADD x: rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, sel=0010, in1=5, in2=7.
//  2. SUB then BLTU back-to-back with out_ready=0 for 2 cycles -> in_ready falls after the 2nd accept.
//     Then raise out_ready -> outputs are SUB(0110) then BLTU(1000), in order, with no loss.
//  3. AUIPC with pc=0x100, imm=0x2000 -> sel=0010, in1=0x100, in2=0x2000.
//     JAL with pc=0x40 -> sel=0010, in1=0x40, in2=4.
//  4. SRAI (funct3=101, funct7b5=1) -> illegal=1, sel=1111. The next valid ADD issues with illegal=0.
//  5. Skid full plus flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1.
//     The flushed instruction never appears at the output.
//  6. FWD_EN build: wb_we=1, wb_rd=3, wb_data=0xAA, rs1_idx=3, rs1_val=0x11 -> in1=0xAA.
//     Same with wb_rd=0 -> in1=0x11.
//  All runs: assert rst_n=0 mid-stall -> all outputs reach their reset values at the next edge.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - handshake and operand bus between decode, issue stage and myALU
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic            illegal;

    modport master (
        output in_valid, opcode, funct3, funct7b5, rs1_idx, rs2_idx,
               rs1_val, rs2_val, imm, pc, out_ready,
        input  in_ready, out_valid, alu_sel, alu_in1, alu_in2, illegal
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7b5, rs1_idx, rs2_idx,
               rs1_val, rs2_val, imm, pc, out_ready,
        output in_ready, out_valid, alu_sel, alu_in1, alu_in2, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I decode to myALU sel/operands behind a 2-entry skid; ALU_ISSUE_FWD_EN adds writeback forwarding
module alu_issue_stage #(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
`ifdef ALU_ISSUE_FWD_EN
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
`endif
    alu_issue_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    logic [XLEN-1:0] rs1_eff, rs2_eff;
`ifdef ALU_ISSUE_FWD_EN
    assign rs1_eff = (wb_we && wb_rd != 5'd0 && wb_rd == bus.rs1_idx) ? wb_data : bus.rs1_val;
    assign rs2_eff = (wb_we && wb_rd != 5'd0 && wb_rd == bus.rs2_idx) ? wb_data : bus.rs2_val;
`else
    logic unused_idx;
    assign unused_idx = ^{bus.rs1_idx, bus.rs2_idx};
    assign rs1_eff    = bus.rs1_val;
    assign rs2_eff    = bus.rs2_val;
`endif

    logic [3:0]      dec_sel;
    logic [XLEN-1:0] dec_in1, dec_in2;
    logic            dec_ill;

    always_comb begin
        dec_sel = 4'b0010;
        dec_in1 = rs1_eff;
        dec_in2 = rs2_eff;
        dec_ill = 1'b0;
        case (bus.opcode)
            OPC_OP, OPC_OPIMM: begin
                if (bus.opcode == OPC_OPIMM) dec_in2 = bus.imm;
                case (bus.funct3)
                    3'b000:  dec_sel = (bus.opcode == OPC_OP && bus.funct7b5) ? 4'b0110 : 4'b0010;
                    3'b001:  dec_sel = 4'b1001;
                    3'b010:  dec_sel = 4'b0111;
                    3'b011:  dec_sel = 4'b1000;
                    3'b100:  dec_sel = 4'b1100;
                    3'b101:  begin dec_sel = 4'b1011; dec_ill = bus.funct7b5; end
                    3'b110:  dec_sel = 4'b0001;
                    default: dec_sel = 4'b0000;
                endcase
            end
            OPC_BR: begin
                dec_sel = bus.funct3[1] ? 4'b1000 : 4'b0111;
                dec_ill = (bus.funct3 == 3'b010 || bus.funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec_in2 = bus.imm;
                dec_ill = (bus.funct3 == 3'b011 || bus.funct3 == 3'b110 || bus.funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec_in2 = bus.imm;
                dec_ill = (bus.funct3 > 3'b010);
            end
            OPC_LUI:   begin dec_in1 = '0;     dec_in2 = bus.imm; end
            OPC_AUIPC: begin dec_in1 = bus.pc; dec_in2 = bus.imm; end
            OPC_JAL:   begin dec_in1 = bus.pc; dec_in2 = XLEN'(PC_STEP); end
            OPC_JALR: begin
                dec_in1 = bus.pc;
                dec_in2 = XLEN'(PC_STEP);
                dec_ill = (bus.funct3 != 3'b000);
            end
            default: dec_ill = 1'b1;
        endcase
        // Unsupported ops force myALU to its zero-output code and pass the raw sources.
        if (dec_ill) begin
            dec_sel = 4'b1111;
            dec_in1 = rs1_eff;
            dec_in2 = rs2_eff;
        end
    end

    logic            out_valid_q, out_valid_d, out_ill_q, out_ill_d;
    logic [3:0]      out_sel_q, out_sel_d;
    logic [XLEN-1:0] out_in1_q, out_in1_d, out_in2_q, out_in2_d;
    logic            skid_valid_q, skid_valid_d, skid_ill_q, skid_ill_d;
    logic [3:0]      skid_sel_q, skid_sel_d;
    logic [XLEN-1:0] skid_in1_q, skid_in1_d, skid_in2_q, skid_in2_d;
    logic            in_ready_q, in_ready_d;
    logic            accept;

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_sel_d    = out_sel_q;
        out_in1_d    = out_in1_q;
        out_in2_d    = out_in2_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_sel_d   = skid_sel_q;
        skid_in1_d   = skid_in1_q;
        skid_in2_d   = skid_in2_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            // in_ready is low whenever skid holds data, so skid refill and drain never collide.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_sel_d    = skid_sel_q;
                out_in1_d    = skid_in1_q;
                out_in2_d    = skid_in2_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_sel_d   = dec_sel;
                out_in1_d   = dec_in1;
                out_in2_d   = dec_in2;
                out_ill_d   = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_sel_d   = dec_sel;
            skid_in1_d   = dec_in1;
            skid_in2_d   = dec_in2;
            skid_ill_d   = dec_ill;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_sel_q    <= '0;
            out_in1_q    <= '0;
            out_in2_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_sel_q   <= '0;
            skid_in1_q   <= '0;
            skid_in2_q   <= '0;
            skid_ill_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_sel_q    <= out_sel_d;
            out_in1_q    <= out_in1_d;
            out_in2_q    <= out_in2_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_sel_q   <= skid_sel_d;
            skid_in1_q   <= skid_in1_d;
            skid_in2_q   <= skid_in2_d;
            skid_ill_q   <= skid_ill_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_sel   = out_sel_q;
    assign bus.alu_in1   = out_in1_q;
    assign bus.alu_in2   = out_in2_q;
    assign bus.illegal   = out_ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [3:0]      sel;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic            ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
    logic            wb_we = 1'b0;
    logic [4:0]      wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
`endif
    int n_checks = 0;
    int n_pass = 0;
    exp_t exp_q[$];

    alu_issue_stage_if #(.XLEN(XLEN)) bus ();

    alu_issue_stage #(.XLEN(XLEN), .PC_STEP(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
`ifdef ALU_ISSUE_FWD_EN
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
`endif
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: mnemonic-level semantics, arithmetic ops looked up by funct3 in a table.
    function automatic exp_t ref_op(logic [6:0] op, logic [2:0] f3, logic b5, logic [XLEN-1:0] r1,
                                    logic [XLEN-1:0] r2, logic [XLEN-1:0] im, logic [XLEN-1:0] p);
        logic [3:0] f3_tab [8] = '{4'b0010, 4'b1001, 4'b0111, 4'b1000, 4'b1100, 4'b1011, 4'b0001, 4'b0000};
        exp_t e;
        bit ok = 1;
        e.ill = 0; e.sel = 4'b0010; e.in1 = r1; e.in2 = r2;
        if (op == 7'h33 || op == 7'h13) begin
            e.sel = f3_tab[f3];
            if (op == 7'h13) e.in2 = im;
            if (op == 7'h33 && f3 == 0 && b5) e.sel = 4'b0110;
            if (f3 == 5 && b5) ok = 0;
        end else if (op == 7'h63) begin
            e.sel = (f3 >= 6) ? 4'b1000 : 4'b0111;
            ok = !(f3 == 2 || f3 == 3);
        end else if (op == 7'h03) begin
            e.in2 = im; ok = (f3 inside {0, 1, 2, 4, 5});
        end else if (op == 7'h23) begin
            e.in2 = im; ok = (f3 <= 2);
        end else if (op == 7'h37) begin
            e.in1 = 0; e.in2 = im;
        end else if (op == 7'h17) begin
            e.in1 = p; e.in2 = im;
        end else if (op == 7'h6f || op == 7'h67) begin
            e.in1 = p; e.in2 = 4;
            if (op == 7'h67) ok = (f3 == 0);
        end else begin
            ok = 0;
        end
        if (!ok) begin e.ill = 1; e.sel = 4'hF; e.in1 = r1; e.in2 = r2; end
        return e;
    endfunction

    task automatic drive(logic v, logic [6:0] op, logic [2:0] f3, logic b5,
                         logic [XLEN-1:0] r1, logic [XLEN-1:0] r2, logic [XLEN-1:0] im, logic [XLEN-1:0] p);
        bus.in_valid = v; bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = b5;
        bus.rs1_val = r1; bus.rs2_val = r2; bus.imm = im; bus.pc = p;
    endtask

    // Advance one clock and update the scoreboard from the expected occupancy.
    task automatic tick();
        bit acc, drn;
        logic [XLEN-1:0] r1, r2;
        exp_t e;
        acc = bus.in_valid && (exp_q.size() < 2);
        drn = (exp_q.size() > 0) && bus.out_ready;
        r1 = bus.rs1_val; r2 = bus.rs2_val;
`ifdef ALU_ISSUE_FWD_EN
        if (wb_we && wb_rd != 0 && wb_rd == bus.rs1_idx) r1 = wb_data;
        if (wb_we && wb_rd != 0 && wb_rd == bus.rs2_idx) r2 = wb_data;
`endif
        e = ref_op(bus.opcode, bus.funct3, bus.funct7b5, r1, r2, bus.imm, bus.pc);
        @(posedge clk);
        if (!rst_n || flush) exp_q.delete();
        else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic drain();
        bus.in_valid = 0; bus.out_ready = 1; flush = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.rs1_idx = 0; bus.rs2_idx = 0; bus.out_ready = 0;
        rst_n = 0; tick(); tick(); rst_n = 1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if ({bus.alu_sel, bus.alu_in1, bus.alu_in2, bus.illegal} !== '0)
            $display("FAIL reset_payload got %h/%h/%h/%b want zeros", bus.alu_sel, bus.alu_in1, bus.alu_in2, bus.illegal);
        else n_pass++;
    endtask

    task automatic test_add();
        bus.out_ready = 1;
        drive(1, 7'h33, 3'b000, 0, 5, 7, 32'h99, 0); tick(); bus.in_valid = 0;
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", bus.out_valid); else n_pass++;
        n_checks++; if ({bus.alu_sel, bus.alu_in1, bus.alu_in2} !== {4'b0010, 32'd5, 32'd7})
            $display("FAIL add_payload got %b/%0d/%0d want 0010/5/7", bus.alu_sel, bus.alu_in1, bus.alu_in2);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 0;
        drive(1, 7'h33, 3'b000, 1, 20, 3, 0, 0); tick();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready1 got %b want 1", bus.in_ready); else n_pass++;
        drive(1, 7'h63, 3'b110, 0, 8, 9, 0, 0); tick();
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_ready2 got %b want 0", bus.in_ready); else n_pass++;
        bus.in_valid = 0; tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_sel !== 4'b0110 || bus.alu_in1 !== 32'd20)
            $display("FAIL b2b_first got v=%b sel=%b in1=%0d want 1/0110/20", bus.out_valid, bus.alu_sel, bus.alu_in1);
        else n_pass++;
        bus.out_ready = 1; tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_sel !== 4'b1000 || bus.alu_in2 !== 32'd9)
            $display("FAIL b2b_second got v=%b sel=%b in2=%0d want 1/1000/9", bus.out_valid, bus.alu_sel, bus.alu_in2);
        else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready3 got %b want 1", bus.in_ready); else n_pass++;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_empty got %b want 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_auipc_jal();
        bus.out_ready = 1;
        drive(1, 7'h17, 0, 0, 1, 2, 32'h2000, 32'h100); tick();
        n_checks++; if ({bus.alu_sel, bus.alu_in1, bus.alu_in2} !== {4'b0010, 32'h100, 32'h2000})
            $display("FAIL auipc got %b/%h/%h want 0010/100/2000", bus.alu_sel, bus.alu_in1, bus.alu_in2);
        else n_pass++;
        drive(1, 7'h6f, 0, 0, 1, 2, 32'h55, 32'h40); tick();
        n_checks++; if ({bus.alu_sel, bus.alu_in1, bus.alu_in2} !== {4'b0010, 32'h40, 32'h4})
            $display("FAIL jal got %b/%h/%h want 0010/40/4", bus.alu_sel, bus.alu_in1, bus.alu_in2);
        else n_pass++;
        drain();
    endtask

    task automatic test_illegal();
        bus.out_ready = 1;
        drive(1, 7'h13, 3'b101, 1, 32'hA, 32'hB, 32'h403, 0); tick();
        n_checks++; if ({bus.illegal, bus.alu_sel, bus.alu_in1, bus.alu_in2} !== {1'b1, 4'hF, 32'hA, 32'hB})
            $display("FAIL srai got ill=%b sel=%b %h/%h want 1/1111/a/b", bus.illegal, bus.alu_sel, bus.alu_in1, bus.alu_in2);
        else n_pass++;
        drive(1, 7'h33, 3'b000, 0, 1, 1, 0, 0); tick();
        n_checks++; if (bus.illegal !== 1'b0 || bus.alu_sel !== 4'b0010)
            $display("FAIL after_illegal got ill=%b sel=%b want 0/0010", bus.illegal, bus.alu_sel);
        else n_pass++;
        drain();
    endtask

    task automatic test_flush();
        bus.out_ready = 0;
        drive(1, 7'h33, 3'b100, 0, 1, 2, 0, 0); tick();
        drive(1, 7'h33, 3'b110, 0, 3, 4, 0, 0); tick();
        drive(1, 7'h37, 0, 0, 0, 0, 32'hDEAD0000, 0); flush = 1; tick();
        flush = 0;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", bus.in_ready); else n_pass++;
        bus.in_valid = 0; bus.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_leak cycle %0d got %b want 0", i, bus.out_valid); else n_pass++;
        end
    endtask

`ifdef ALU_ISSUE_FWD_EN
    task automatic test_fwd();
        bus.out_ready = 1; bus.rs1_idx = 3; bus.rs2_idx = 4;
        wb_we = 1; wb_rd = 3; wb_data = 32'hAA;
        drive(1, 7'h33, 0, 0, 32'h11, 32'h22, 0, 0); tick();
        n_checks++; if (bus.alu_in1 !== 32'hAA) $display("FAIL fwd_hit got %h want aa", bus.alu_in1); else n_pass++;
        wb_rd = 0; tick();
        n_checks++; if (bus.alu_in1 !== 32'h11) $display("FAIL fwd_x0 got %h want 11", bus.alu_in1); else n_pass++;
        wb_we = 0; drain();
    endtask
`endif

    task automatic test_random();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h00};
        for (int c = 0; c < 400; c++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 9)];
            if (op == 7'h00) op = 7'($urandom);
            drive(1'($urandom_range(0, 99) < 60), op, 3'($urandom), 1'($urandom),
                  $urandom, $urandom, $urandom, $urandom);
            bus.rs1_idx = 5'($urandom); bus.rs2_idx = 5'($urandom);
            bus.out_ready = ($urandom_range(0, 99) < 55);
            flush = ($urandom_range(0, 99) < 4);
            tick();
            n_checks++; if (bus.out_valid !== (exp_q.size() > 0))
                $display("FAIL rnd_valid c=%0d got %b want %b", c, bus.out_valid, exp_q.size() > 0);
            else n_pass++;
            n_checks++; if (bus.in_ready !== (exp_q.size() < 2))
                $display("FAIL rnd_ready c=%0d got %b want %b", c, bus.in_ready, exp_q.size() < 2);
            else n_pass++;
            if (exp_q.size() > 0) begin
                n_checks++; if ({bus.alu_sel, bus.alu_in1, bus.alu_in2, bus.illegal} !== exp_q[0])
                    $display("FAIL rnd_payload c=%0d got %b/%h/%h/%b want %b/%h/%h/%b", c, bus.alu_sel, bus.alu_in1,
                             bus.alu_in2, bus.illegal, exp_q[0].sel, exp_q[0].in1, exp_q[0].in2, exp_q[0].ill);
                else n_pass++;
            end
        end
        flush = 0;
        drain();
    endtask

    task automatic test_reset_mid_stall();
        bus.out_ready = 0;
        drive(1, 7'h33, 3'b111, 0, 5, 6, 0, 0); tick(); tick();
        rst_n = 0; tick(); rst_n = 1; bus.in_valid = 0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL rst_stall_ctrl got v=%b r=%b want 0/1", bus.out_valid, bus.in_ready);
        else n_pass++;
        n_checks++; if ({bus.alu_sel, bus.alu_in1, bus.alu_in2, bus.illegal} !== '0)
            $display("FAIL rst_stall_payload got %h/%h/%h/%b want zeros", bus.alu_sel, bus.alu_in1, bus.alu_in2, bus.illegal);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_auipc_jal();
        test_illegal();
        test_flush();
`ifdef ALU_ISSUE_FWD_EN
        test_fwd();
`endif
        test_random();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
